// File: rtl/ac_ph_pkg.sv
// Shared definitions for the AC/phase estimator datapath.
// Holds the default phase/amplitude widths so the averager matches the estimator
// outputs. Also holds the binary-angle type, the pi constant and the averager FSM
// state type.
package ac_ph_pkg;

  localparam int unsigned DEF_PH_WIDTH = 32;
  localparam int unsigned DEF_AC_WIDTH = 32;

  // Signed binary angle: full scale 2^DEF_PH_WIDTH corresponds to 2*pi.
  typedef logic signed [DEF_PH_WIDTH-1:0] angle_t;

  localparam angle_t ANGLE_PI = angle_t'({1'b1, {(DEF_PH_WIDTH-1){1'b0}}});

  typedef enum logic {
    StFirst,
    StAcc
  } avg_state_e;

endpackage

// File: rtl/ac_ph_avg.sv
// Frame-result averager. It averages 2^LOG2_N (phase, amplitude) pairs. Phases
// are accumulated as wrap-safe offsets from the block's first sample. It also
// tracks the peak |phase - ref| within each block.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   i_vld        input sample valid (no backpressure)
//   ph, ac       signed phase difference, unsigned amplitude
//   clear        synchronous flush of partial block, o_vld and ovf
//   o_vld, o_rdy result handshake
//   avg_ph       block-mean phase (modulo 2*pi)
//   avg_ac       block-mean amplitude
//   ph_spread    max |ph - ref| within the block (unsigned)
//   ovf          sticky: an unread result was overwritten
module ac_ph_avg
  import ac_ph_pkg::*;
#(
  parameter int unsigned PH_WIDTH = DEF_PH_WIDTH,
  parameter int unsigned AC_WIDTH = DEF_AC_WIDTH,
  parameter int unsigned LOG2_N   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_vld,
  input  logic [PH_WIDTH-1:0] ph,
  input  logic [AC_WIDTH-1:0] ac,
  input  logic                clear,
  output logic                o_vld,
  input  logic                o_rdy,
  output logic [PH_WIDTH-1:0] avg_ph,
  output logic [AC_WIDTH-1:0] avg_ac,
  output logic [PH_WIDTH-1:0] ph_spread,
  output logic                ovf
);

  localparam int unsigned SPW = PH_WIDTH + LOG2_N;
  localparam int unsigned SAW = AC_WIDTH + LOG2_N;
  localparam logic [LOG2_N-1:0] CNT_LAST = '1;

  avg_state_e        state_q, state_d;
  logic [LOG2_N-1:0] cnt_q, cnt_d;

  logic [PH_WIDTH-1:0] ref_q;
  logic [SPW-1:0]      sum_ph_q;
  logic [SAW-1:0]      sum_ac_q;
  logic [PH_WIDTH-1:0] spread_q;

  logic                first;
  logic                take;
  logic                done;
  logic [PH_WIDTH-1:0] ref_eff;
  logic [PH_WIDTH-1:0] delta;
  logic [PH_WIDTH-1:0] abs_delta;
  logic [SPW-1:0]      sum_ph_acc;
  logic [SAW-1:0]      sum_ac_acc;
  logic [PH_WIDTH-1:0] spread_base;
  logic [PH_WIDTH-1:0] spread_acc;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFirst;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state; clear wins over a same-cycle sample
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = StFirst;
      cnt_d   = '0;
    end else if (i_vld) begin
      unique case (state_q)
        StFirst: begin
          state_d = StAcc;
          cnt_d   = LOG2_N'(1);
        end
        StAcc: begin
          if (cnt_q == CNT_LAST) begin
            state_d = StFirst;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + LOG2_N'(1);
          end
        end
        default: begin
          state_d = StFirst;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM outputs and per-sample arithmetic
  always_comb begin
    first = (state_q == StFirst);
    take  = i_vld & ~clear;
    done  = take & (state_q == StAcc) & (cnt_q == CNT_LAST);

    ref_eff = first ? ph : ref_q;
    // Natural PH_WIDTH wrap makes the signed delta the shortest arc.
    delta     = ph - ref_eff;
    // Negating the most negative angle yields 2^(PH_WIDTH-1) as an unsigned value.
    abs_delta = delta[PH_WIDTH-1] ? (-delta) : delta;

    sum_ph_acc  = (first ? '0 : sum_ph_q) + {{LOG2_N{delta[PH_WIDTH-1]}}, delta};
    sum_ac_acc  = (first ? '0 : sum_ac_q) + SAW'(ac);
    spread_base = first ? '0 : spread_q;
    spread_acc  = (abs_delta > spread_base) ? abs_delta : spread_base;
  end

  // Accumulators and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q     <= '0;
      sum_ph_q  <= '0;
      sum_ac_q  <= '0;
      spread_q  <= '0;
      o_vld     <= 1'b0;
      avg_ph    <= '0;
      avg_ac    <= '0;
      ph_spread <= '0;
      ovf       <= 1'b0;
    end else if (clear) begin
      ref_q    <= '0;
      sum_ph_q <= '0;
      sum_ac_q <= '0;
      spread_q <= '0;
      o_vld    <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (take) begin
        if (done) begin
          ref_q    <= '0;
          sum_ph_q <= '0;
          sum_ac_q <= '0;
          spread_q <= '0;
        end else begin
          ref_q    <= ref_eff;
          sum_ph_q <= sum_ph_acc;
          sum_ac_q <= sum_ac_acc;
          spread_q <= spread_acc;
        end
      end

      if (done) begin
        // Dropping the low LOG2_N bits is the floor divide; the upper slice of
        // the signed phase sum is already the arithmetic shift, truncated.
        avg_ph    <= ref_eff + sum_ph_acc[SPW-1:LOG2_N];
        avg_ac    <= sum_ac_acc[SAW-1:LOG2_N];
        ph_spread <= spread_acc;
        o_vld     <= 1'b1;
        if (o_vld && !o_rdy) begin
          ovf <= 1'b1;
        end
      end else if (o_vld && o_rdy) begin
        o_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ac_ph_avg.sv
module tb_ac_ph_avg;

  logic        clk;
  logic        rst;
  logic        i_vld;
  logic [31:0] ph;
  logic [31:0] ac;
  logic        clear;
  logic        o_vld;
  logic        o_rdy;
  logic [31:0] avg_ph;
  logic [31:0] avg_ac;
  logic [31:0] ph_spread;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  ac_ph_avg #(
    .PH_WIDTH(32),
    .AC_WIDTH(32),
    .LOG2_N  (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_vld    (i_vld),
    .ph       (ph),
    .ac       (ac),
    .clear    (clear),
    .o_vld    (o_vld),
    .o_rdy    (o_rdy),
    .avg_ph   (avg_ph),
    .avg_ac   (avg_ac),
    .ph_spread(ph_spread),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; the DUT samples them on the next rising edge.
  task automatic put(input logic [31:0] p, input logic [31:0] a);
    @(negedge clk);
    i_vld = 1'b1;
    ph    = p;
    ac    = a;
    clear = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    i_vld = 1'b0;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_vld = 1'b0; ph = '0; ac = '0; clear = 1'b0; o_rdy = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (o_vld !== 1'b0) begin bad++; $display("FAIL reset o_vld got=%b exp=0", o_vld); end
    total++; if (avg_ph !== 32'd0) begin bad++; $display("FAIL reset avg_ph got=%h exp=0", avg_ph); end
    total++; if (avg_ac !== 32'd0) begin bad++; $display("FAIL reset avg_ac got=%h exp=0", avg_ac); end
    total++; if (ph_spread !== 32'd0) begin bad++; $display("FAIL reset spread got=%h exp=0", ph_spread); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset ovf got=%b exp=0", ovf); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    for (int i = 0; i < 8; i++) put(32'd1000, 32'd500);
    idle();
    total++; if (o_vld !== 1'b1) begin bad++; $display("FAIL basic o_vld got=%b exp=1", o_vld); end
    total++; if (avg_ph !== 32'd1000) begin bad++; $display("FAIL basic avg_ph got=%0d exp=1000", avg_ph); end
    total++; if (avg_ac !== 32'd500) begin bad++; $display("FAIL basic avg_ac got=%0d exp=500", avg_ac); end
    total++; if (ph_spread !== 32'd0) begin bad++; $display("FAIL basic spread got=%0d exp=0", ph_spread); end
    idle();
    total++; if (o_vld !== 1'b0) begin bad++; $display("FAIL basic o_vld_drop got=%b exp=0", o_vld); end
  endtask

  task automatic test_wrap();
    // ref=0x7FFFFFF0, deltas alternate 0,+0x20: sum 0x80, mean +0x10 wraps past pi
    for (int i = 0; i < 8; i++) put((i % 2 == 0) ? 32'h7FFF_FFF0 : 32'h8000_0010, 32'd1);
    idle();
    total++; if (o_vld !== 1'b1) begin bad++; $display("FAIL wrap o_vld got=%b exp=1", o_vld); end
    total++; if (avg_ph !== 32'h8000_0000) begin bad++; $display("FAIL wrap avg_ph got=%h exp=80000000", avg_ph); end
    total++; if (ph_spread !== 32'h20) begin bad++; $display("FAIL wrap spread got=%h exp=20", ph_spread); end
    idle();
  endtask

  task automatic test_ramp();
    // ph -3..4: ref -3, deltas 0..7 sum 28, floor(28/8)=3, -3+3=0; ac 1..8 sum 36 -> 4
    for (int i = -3; i <= 4; i++) put(32'(i), 32'(i + 4));
    idle();
    total++; if (o_vld !== 1'b1) begin bad++; $display("FAIL ramp o_vld got=%b exp=1", o_vld); end
    total++; if (avg_ph !== 32'd0) begin bad++; $display("FAIL ramp avg_ph got=%h exp=0", avg_ph); end
    total++; if (avg_ac !== 32'd4) begin bad++; $display("FAIL ramp avg_ac got=%0d exp=4", avg_ac); end
    total++; if (ph_spread !== 32'd7) begin bad++; $display("FAIL ramp spread got=%0d exp=7", ph_spread); end
    idle();
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    o_rdy = 1'b0;
    for (int i = 0; i < 8; i++) put(32'd1000, 32'd500);
    put(32'hFFFF_FFFD, 32'd1);
    total++; if (o_vld !== 1'b1) begin bad++; $display("FAIL bp first_vld got=%b exp=1", o_vld); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL bp first_ovf got=%b exp=0", ovf); end
    for (int i = -2; i <= 4; i++) put(32'(i), 32'(i + 4));
    idle();
    total++; if (o_vld !== 1'b1) begin bad++; $display("FAIL bp held_vld got=%b exp=1", o_vld); end
    total++; if (avg_ac !== 32'd4) begin bad++; $display("FAIL bp second_ac got=%0d exp=4", avg_ac); end
    total++; if (avg_ph !== 32'd0) begin bad++; $display("FAIL bp second_ph got=%h exp=0", avg_ph); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL bp ovf_set got=%b exp=1", ovf); end
    o_rdy = 1'b1;
    @(negedge clk);
    o_rdy = 1'b0;
    total++; if (o_vld !== 1'b0) begin bad++; $display("FAIL bp accept_vld got=%b exp=0", o_vld); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL bp ovf_sticky got=%b exp=1", ovf); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL bp ovf_clear got=%b exp=0", ovf); end
    total++; if (avg_ac !== 32'd4) begin bad++; $display("FAIL bp clear_keeps_data got=%0d exp=4", avg_ac); end
    o_rdy = 1'b1;
  endtask

  task automatic test_sparse();
    for (int i = -3; i <= 4; i++) begin
      put(32'(i), 32'(i + 4));
      if (i < 4) repeat (8) idle();
    end
    total++; if (o_vld !== 1'b0) begin bad++; $display("FAIL sparse early_vld got=%b exp=0", o_vld); end
    idle();
    total++; if (o_vld !== 1'b1) begin bad++; $display("FAIL sparse o_vld got=%b exp=1", o_vld); end
    total++; if (avg_ph !== 32'd0) begin bad++; $display("FAIL sparse avg_ph got=%h exp=0", avg_ph); end
    total++; if (avg_ac !== 32'd4) begin bad++; $display("FAIL sparse avg_ac got=%0d exp=4", avg_ac); end
    total++; if (ph_spread !== 32'd7) begin bad++; $display("FAIL sparse spread got=%0d exp=7", ph_spread); end
    idle();
  endtask

  task automatic test_clear_drop();
    for (int i = 0; i < 3; i++) put(32'd500, 32'd1);
    @(negedge clk);
    clear = 1'b1; i_vld = 1'b1; ph = 32'd9999; ac = 32'd9999;
    for (int i = 0; i < 8; i++) put(32'd50, 32'd7);
    idle();
    total++; if (o_vld !== 1'b1) begin bad++; $display("FAIL clear o_vld got=%b exp=1", o_vld); end
    total++; if (avg_ph !== 32'd50) begin bad++; $display("FAIL clear avg_ph got=%0d exp=50", avg_ph); end
    total++; if (avg_ac !== 32'd7) begin bad++; $display("FAIL clear avg_ac got=%0d exp=7", avg_ac); end
    idle();
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 8; i++) put(32'd300, 32'd20);
    idle();
    for (int i = 0; i < 5; i++) put(32'd1000, 32'd500);
    @(negedge clk);
    i_vld = 1'b0;
    rst   = 1'b1;
    #1;
    total++; if (avg_ph !== 32'd0) begin bad++; $display("FAIL rst avg_ph got=%h exp=0", avg_ph); end
    total++; if (avg_ac !== 32'd0) begin bad++; $display("FAIL rst avg_ac got=%h exp=0", avg_ac); end
    total++; if (o_vld !== 1'b0) begin bad++; $display("FAIL rst o_vld got=%b exp=0", o_vld); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) put(32'd200, 32'd10);
    put(32'd200, 32'd10);
    total++; if (o_vld !== 1'b0) begin bad++; $display("FAIL rst early_vld got=%b exp=0", o_vld); end
    idle();
    total++; if (o_vld !== 1'b1) begin bad++; $display("FAIL rst o_vld_after got=%b exp=1", o_vld); end
    total++; if (avg_ph !== 32'd200) begin bad++; $display("FAIL rst avg_ph_after got=%0d exp=200", avg_ph); end
    total++; if (avg_ac !== 32'd10) begin bad++; $display("FAIL rst avg_ac_after got=%0d exp=10", avg_ac); end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_ramp();
    test_backpressure();
    test_sparse();
    test_clear_drop();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ac_ph_avg.md
# ac_ph_avg

Frame-result averager placed directly downstream of the AC/phase estimator. Consumes one (phase-difference, amplitude) pair per completed estimator frame, averages 2^LOG2_N consecutive pairs with wrap-safe binary-angle arithmetic, and presents the result through a valid/ready output register. It also reports the peak phase deviation within each block.

## Interface
- PH_WIDTH, 32: phase width; signed binary angle, full scale 2^PH_WIDTH = 2π.
- AC_WIDTH, 32: amplitude width, unsigned.
- LOG2_N, 3: log2 of the block length; N = 2^LOG2_N results averaged. Legal range 1..8.

Reset and clocking: **one clock; reset is asynchronous and active-high.**

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- i_vld  in  1  one result accepted per cycle when high; no backpressure toward the estimator.
- ph  in  PH_WIDTH  signed phase difference.
- ac  in  AC_WIDTH  unsigned amplitude.
- clear  in  1  synchronous flush of the partial block, output register and ovf.
- o_vld  out  1  averaged result held valid.
- o_rdy  in  1  consumer accepts when o_vld & o_rdy.
- avg_ph  out  PH_WIDTH  block-mean phase, signed, modulo 2π.
- avg_ac  out  AC_WIDTH  block-mean amplitude.
- ph_spread  out  PH_WIDTH  unsigned max |ph − ref| within the block.
- ovf  out  1  sticky; set when an unread result is overwritten.

## Operation
- FSM states: FIRST (count = 0) and ACC (count 1..N−1).
- **FIRST**, on i_vld:
  - ref ← ph; delta = 0; sum_ph ← 0; sum_ac ← ac; spread ← 0.
  - Go to ACC, count ← 1.
- **ACC**, on i_vld:
  - delta = ph − ref, computed in PH_WIDTH with natural wrap and read as signed (always the shortest arc).
  - sum_ph += sign-extended delta. Width is PH_WIDTH+LOG2_N, so it never overflows.
  - sum_ac += ac. Width is AC_WIDTH+LOG2_N.
  - spread ← max(spread, |delta|). |−2^(PH_WIDTH−1)| = 2^(PH_WIDTH−1), which fits the unsigned field.
- **Completion:** on the N-th accepted sample, the totals include the current sample.
  - avg_ph ← ref + (sum_ph >>> LOG2_N), arithmetic shift (floor), truncated to PH_WIDTH (wraps).
  - avg_ac ← sum_ac >> LOG2_N (floor).
  - ph_spread ← final spread.
  - o_vld ← 1; FSM returns to FIRST.
- **Output register rules:**
  - Accepted (o_vld & o_rdy) with no new result: o_vld ← 0.
  - New result in the same cycle as an accept: new data loads, o_vld stays 1, ovf unchanged.
  - New result while o_vld & !o_rdy: data overwritten, o_vld stays 1, ovf ← 1.
- **clear:** has priority over i_vld; a sample in the same cycle is dropped.
  - FSM ← FIRST, accumulators ← 0, o_vld ← 0, ovf ← 0.
  - Data outputs keep their value.
- **Reset values:** o_vld, avg_ph, avg_ac, ph_spread and ovf = 0; FSM = FIRST; all accumulators = 0.
  - Reset in mid-block discards the partial block.

## Timing
- Latency: o_vld rises on the clock edge that accepts the N-th sample, i.e. visible in the following cycle.
- Back-to-back blocks need no bubble: a sample in the cycle right after completion is the FIRST sample of the next block.
- Sample gaps of any length are allowed; the result depends only on the accepted samples.
- Outputs are registered. No combinational path from inputs to outputs except nothing: o_rdy affects only state.

## Structure
- Shared package ac_ph_pkg holds:
  - default PH_WIDTH and AC_WIDTH, so they match the estimator outputs;
  - a binary-angle typedef;
  - the ANGLE_PI constant, 2^(PH_WIDTH−1).
- Single module; no sub-module needed. Delta/abs/max is combinational logic inside it.

## Test plan
All scenarios use LOG2_N = 3 (N = 8) and o_rdy = 1 unless stated.
1. 8 back-to-back samples with ph = 1000, ac = 500 → one o_vld cycle with avg_ph = 1000, avg_ac = 500, ph_spread = 0.
2. Wrap: ph alternating 0x7FFF_FFF0 and 0x8000_0010 (8 samples) → avg_ph = 0x8000_0000, ph_spread = 0x20. A naive average would give ~0, which is wrong.
3. ph = −3, −2, …, 4 with ac = 1..8 → avg_ph = 0, avg_ac = 4 (36 >> 3), ph_spread = 7.
4. Backpressure: o_rdy = 0 for 16 samples → o_vld held, data = second block, ovf = 1. Then o_rdy = 1 for 1 cycle → o_vld = 0, ovf stays 1. Then clear → ovf = 0.
5. Sparse i_vld (1 valid every 9 cycles, matching the estimator's cadence), rerunning case 3 → identical outputs. o_vld rises exactly 1 cycle after the 8th valid.
6. rst asserted after 5 samples of case 1 → all outputs 0 immediately. The next 8 samples with ph = 200, ac = 10 → avg_ph = 200, avg_ac = 10.
